// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO edge poller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option PIO_POLL_TIMESTAMP_EN selects timestamped events.
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        RD_CAP = 2'd2,
        CLR    = 2'd3
    } state_t;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

`ifdef PIO_POLL_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

endpackage

// File: rtl/pio_evt_fifo.sv
// Synchronous show-ahead FIFO; pop_data is the head entry whenever empty=0.
// Latency: a push is visible on pop_data/level the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full is pre-pop.
module pio_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // Zero when empty so the stream output never shows stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pio_edge_poller.sv
// Avalon-MM master polling a PIO edge-capture register, clearing seen bits, queueing non-zero masks.
// Latency: RD_REQ to evt_valid is 3 cycles; a poll is POLL_DIV+3 cycles (POLL_DIV+2 for zero mask).
// Backpressure: evt stream is valid/ready; a full FIFO drops the event and sets sticky overflow.
// Build option PIO_POLL_TIMESTAMP_EN prefixes each event with a free-running TS_W timestamp.
module pio_edge_poller
    import pio_poll_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_DIV   = 4,
    parameter int TS_W       = 16,
    localparam int EVT_W = DATA_W + (TS_EN ? TS_W : 0),
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  poll_cnt;
    logic [CNT_W-1:0]  poll_cnt_nxt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] rd_mask;
    logic [EVT_W-1:0]  evt_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_evt;
    logic              drop_evt;

    // Only the edge-capture field of the readdata bus is meaningful.
    assign rd_mask = avm_readdata[DATA_W-1:0];

    generate
        if (DATA_W < 32) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^avm_readdata[31:DATA_W];
        end
    endgenerate

    // Fullness is sampled before any same-cycle pop, so a full FIFO always drops.
    assign push_evt = (state == CLR) && !fifo_full;
    assign drop_evt = (state == CLR) && fifo_full;

    // FSM state, poll divider and captured mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            poll_cnt <= '0;
            mask     <= '0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= poll_cnt_nxt;
            if (state == RD_CAP) mask <= rd_mask;
        end
    end

    // Next-state and Avalon drive; the bus idles at the data address, deselected.
    always_comb begin
        state_nxt      = state;
        poll_cnt_nxt   = poll_cnt;
        avm_address    = PIO_ADDR_DATA;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        case (state)
            IDLE: begin
                if (!enable) begin
                    poll_cnt_nxt = '0;
                end else if (poll_cnt == CNT_W'(POLL_DIV - 1)) begin
                    poll_cnt_nxt = '0;
                    state_nxt    = RD_REQ;
                end else begin
                    poll_cnt_nxt = poll_cnt + CNT_W'(1);
                end
            end
            RD_REQ: begin
                avm_address    = PIO_ADDR_EDGE;
                avm_chipselect = 1'b1;
                state_nxt      = RD_CAP;
            end
            RD_CAP: begin
                avm_address = PIO_ADDR_EDGE;
                state_nxt   = (rd_mask == '0) ? IDLE : CLR;
            end
            CLR: begin
                // Write back exactly what was read; later edges on other bits survive.
                avm_address    = PIO_ADDR_EDGE;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = 32'(mask);
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky overflow; a drop in the same cycle wins over the clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop_evt) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef PIO_POLL_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_cap;

    // Free-running timestamp, captured alongside the mask read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_cap <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (state == RD_CAP) ts_cap <= ts_cnt;
        end
    end

    assign evt_word = {ts_cap, mask};
`else
    assign evt_word = mask;
`endif

    assign evt_valid = !fifo_empty;

    pio_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_evt),
        .push_data (evt_word),
        .pop       (evt_valid && evt_ready),
        .pop_data  (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_pio_edge_poller.sv
// Testbench for pio_edge_poller: PIO edge-capture slave model, scoreboard and random stimulus.
// Expected events come from the slave register contents at each read request.
// Build with PIO_POLL_TIMESTAMP_EN to also check timestamps across the counter wrap.
`timescale 1ns/1ps
module tb_pio_edge_poller;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int POLL_DIV   = 4;
    localparam int TS_W       = 16;
`ifdef PIO_POLL_TIMESTAMP_EN
    localparam int EVT_W = TS_W + DATA_W;
`else
    localparam int EVT_W = DATA_W;
`endif
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             evt_valid;
    logic [EVT_W-1:0] evt_data;
    logic             evt_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             ovf_clr;

    logic [7:0]       edges;
    logic [7:0]       slave_cap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_edge_poller #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .POLL_DIV   (POLL_DIV),
        .TS_W       (TS_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .evt_ready      (evt_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // PIO slave: registered readdata (junk in upper bits), clear wins over a new edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_cap    <= 8'h00;
            avm_readdata <= 32'h0;
        end else begin
            avm_readdata <= (avm_address == 2'd3) ? {24'hA5C35A, slave_cap} : 32'h0;
            slave_cap    <= (slave_cap | edges) &
                            ~((avm_chipselect && !avm_write_n && avm_address == 2'd3) ?
                              avm_writedata[7:0] : 8'h00);
        end
    end

    // Scoreboard / monitor state
    int               cyc      = 0;
    int               cap_at   = -10;
    int               clr_at   = -10;
    int               last_req = -1000;
    int               last_gap = 0;
    int               req_cnt  = 0;
    bit               en_ok    = 1'b0;
    bit               exp_ovf  = 1'b0;
    logic [7:0]       clr_mask;
    logic [EVT_W-1:0] clr_word;
    logic [EVT_W-1:0] exp_q[$];
    logic [EVT_W-1:0] evt_log[$];
    bit               m_is_req;
    bit               m_full;
    logic [7:0]       m_r;

    // Monitor: samples mid-cycle, checks bus, stream, level and overflow every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            m_is_req = avm_chipselect && avm_write_n && (avm_address == 2'd3);
            if (cyc == clr_at) begin
                chk({avm_address, avm_chipselect, avm_write_n} == 4'b1110, "clr_bus",
                    {avm_address, avm_chipselect, avm_write_n}, 4'b1110);
                chk(avm_writedata == {24'h0, clr_mask}, "clr_writedata",
                    avm_writedata, {24'h0, clr_mask});
            end else if (cyc == cap_at) begin
                chk({avm_address, avm_chipselect, avm_write_n} == 4'b1101, "cap_bus",
                    {avm_address, avm_chipselect, avm_write_n}, 4'b1101);
            end else if (!m_is_req) begin
                chk({avm_address, avm_chipselect, avm_write_n, avm_writedata} == {4'b0001, 32'h0},
                    "idle_bus", {avm_address, avm_chipselect, avm_write_n, avm_writedata},
                    {4'b0001, 32'h0});
            end

            // Poll period while enable stays high
            if (!enable) begin
                en_ok = 1'b0;
            end else if (en_ok) begin
                if (m_is_req) chk(cyc - last_req == last_gap, "poll_gap", cyc - last_req, last_gap);
                else          chk(cyc - last_req < last_gap, "poll_late", cyc - last_req, last_gap);
            end

            // Event stream against the expected queue
            chk(evt_valid == (exp_q.size() != 0), "evt_valid", evt_valid, exp_q.size() != 0);
            chk(fifo_level == LVL_W'(exp_q.size()), "fifo_level", fifo_level, exp_q.size());
            chk(overflow == exp_ovf, "overflow", overflow, exp_ovf);
            if (exp_q.size() != 0) begin
                chk(evt_data == exp_q[0], "evt_data", evt_data, exp_q[0]);
            end else begin
                chk(evt_data == '0, "evt_data_idle", evt_data, 0);
            end
            m_full = (exp_q.size() == FIFO_DEPTH);
            if (exp_q.size() != 0 && evt_ready) begin
                evt_log.push_back(evt_data);
                void'(exp_q.pop_front());
            end
            if (cyc == clr_at && m_full) exp_ovf = 1'b1;
            else if (ovf_clr)            exp_ovf = 1'b0;
            if (cyc == clr_at && !m_full) exp_q.push_back(clr_word);

            // A read request: the slave's current capture becomes the expected event.
            if (m_is_req) begin
                m_r      = slave_cap;
                cap_at   = cyc + 1;
                last_req = cyc;
                last_gap = POLL_DIV + ((m_r != 8'h00) ? 3 : 2);
                en_ok    = enable;
                req_cnt++;
                if (m_r != 8'h00) begin
                    clr_at   = cyc + 2;
                    clr_mask = m_r;
`ifdef PIO_POLL_TIMESTAMP_EN
                    clr_word = {TS_W'(cyc + 1), m_r};
`else
                    clr_word = m_r;
`endif
                end
            end
            cyc++;
        end
    end

    // Wait for the next read request; returns during its RD_CAP cycle.
    task automatic wait_req(input int budget, input string name);
        int  r0;
        bit  seen;
        r0   = req_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (req_cnt != r0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(seen, name, seen, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [EVT_W-1:0] ent;
    int               base;

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        edges     = 8'h00;

        // Reset values while reset is held
        cycles(3);
        chk(avm_address == 2'd0, "rst_address", avm_address, 0);
        chk(avm_chipselect == 1'b0, "rst_chipselect", avm_chipselect, 0);
        chk(avm_write_n == 1'b1, "rst_write_n", avm_write_n, 1);
        chk(avm_writedata == 32'h0, "rst_writedata", avm_writedata, 0);
        chk(evt_valid == 1'b0, "rst_evt_valid", evt_valid, 0);
        chk(evt_data == '0, "rst_evt_data", evt_data, 0);
        chk(fifo_level == '0, "rst_fifo_level", fifo_level, 0);
        chk(overflow == 1'b0, "rst_overflow", overflow, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Disabled: no bus activity for 50 cycles
        cycles(50);
        chk(req_cnt == 0, "disabled_no_poll", req_cnt, 0);

        // Zero captures: reads every POLL_DIV+2 cycles, no writes, no events
        enable    = 1'b1;
        evt_ready = 1'b1;
        base      = req_cnt;
        cycles(40);
        chk(req_cnt - base >= 6, "zero_poll_count", req_cnt - base, 6);
        chk(evt_log.size() == 0, "zero_no_event", evt_log.size(), 0);

        // Single capture 0x05, cleared by the write-back
        wait_req(20, "wait_req_a");
        edges = 8'h05;
        cycles(1);
        edges = 8'h00;
        cycles(20);
        chk(evt_log.size() == 1, "ev05_count", evt_log.size(), 1);
        ent = (evt_log.size() != 0) ? evt_log[evt_log.size() - 1] : '0;
        chk(ent[7:0] == 8'h05, "ev05_mask", ent[7:0], 8'h05);
        chk(slave_cap == 8'h00, "ev05_slave_cleared", slave_cap, 0);

        // Edge on bit 1 arriving after the read of a 0x04 capture survives
        wait_req(20, "wait_req_b");
        edges = 8'h04;
        cycles(1);
        edges = 8'h00;
        wait_req(20, "wait_req_c");
        edges = 8'h02;
        cycles(1);
        edges = 8'h00;
        base = evt_log.size();
        cycles(20);
        chk(evt_log.size() - base == 2, "split_count", evt_log.size() - base, 2);
        ent = (evt_log.size() >= 2) ? evt_log[evt_log.size() - 2] : '0;
        chk(ent[7:0] == 8'h04, "split_first", ent[7:0], 8'h04);
        ent = (evt_log.size() >= 1) ? evt_log[evt_log.size() - 1] : '0;
        chk(ent[7:0] == 8'h02, "split_second", ent[7:0], 8'h02);
        chk(slave_cap == 8'h00, "split_slave_cleared", slave_cap, 0);

        // Saturation with no consumer
        evt_ready = 1'b0;
        edges     = 8'h01;
        cycles(160);
        edges = 8'h00;
        cycles(20);
        chk(fifo_level == LVL_W'(FIFO_DEPTH), "sat_level", fifo_level, FIFO_DEPTH);
        chk(overflow == 1'b1, "sat_overflow", overflow, 1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        chk(overflow == 1'b0, "ovf_cleared", overflow, 0);
        base      = evt_log.size();
        evt_ready = 1'b1;
        wait_drain(60, "sat_drain");
        chk(evt_log.size() - base == FIFO_DEPTH, "drain_count", evt_log.size() - base, FIFO_DEPTH);
        for (int i = base; i < evt_log.size(); i++) begin
            ent = evt_log[i];
            chk(ent[7:0] == 8'h01, "drain_mask", ent[7:0], 8'h01);
        end
        chk(fifo_level == '0, "drain_level", fifo_level, 0);

        // Randomised traffic, backpressure, clears and brief enable drops
        base = req_cnt;
        for (int i = 0; i < 1500; i++) begin
            edges     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            enable    = ($urandom_range(0, 49) != 0);
            cycles(1);
        end
        edges     = 8'h00;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        enable    = 1'b1;
        cycles(30);
        wait_drain(60, "rand_drain");
        chk(req_cnt - base > 150, "rand_poll_activity", req_cnt - base, 150);
        chk(fifo_level == '0, "rand_final_level", fifo_level, 0);

`ifdef PIO_POLL_TIMESTAMP_EN
        // Consecutive events across the timestamp wrap differ by one poll period
        while (cyc < 65480) @(posedge clk);
        #1;
        base  = evt_log.size();
        edges = 8'h01;
        cycles(140);
        edges = 8'h00;
        cycles(20);
        chk(evt_log.size() - base >= 15, "ts_event_count", evt_log.size() - base, 15);
        for (int i = base + 1; i < evt_log.size(); i++) begin
            logic [EVT_W-1:0] a;
            logic [EVT_W-1:0] b;
            logic [TS_W-1:0]  d;
            a = evt_log[i - 1];
            b = evt_log[i];
            d = b[EVT_W-1:DATA_W] - a[EVT_W-1:DATA_W];
            chk(d == TS_W'(POLL_DIV + 3), "ts_delta", d, POLL_DIV + 3);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pio_edge_poller.md
# pio_edge_poller

Avalon-MM master that sits directly downstream of the 8-bit edge-capturing input PIO. It periodically reads the PIO edge-capture register (address 3), writes back exactly the bits it saw to clear them, and pushes each non-zero capture mask into an event FIFO. The FIFO drains over a valid/ready stream. This removes CPU polling of the input PIO from the testbench control path.

## Interface
Parameters:
- DATA_W, 8, PIO input width; equals width of the edge-capture field
- FIFO_DEPTH, 16, event FIFO entries; power of two, ≥2
- POLL_DIV, 4, idle cycles between polls; ≥1
- TS_W, 16, timestamp width (used only with TIMESTAMP_EN)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low; clock clk
- enable  in  1  polling enable
- avm_address  out  2  PIO register address
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  clear mask, zero-extended
- avm_readdata  in  32  PIO readdata; registered by slave, valid 1 cycle after address
- evt_valid  out  1  event available
- evt_data  out  EVT_W  event word; EVT_W = TS_W+DATA_W with TIMESTAMP_EN, else DATA_W
- evt_ready  in  1  consumer accepts event
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky; event dropped because FIFO full
- ovf_clr  in  1  clears overflow

## Operation
- Reset values: avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, evt_valid=0, evt_data=0, fifo_level=0, overflow=0. FSM in IDLE; poll counter=0; timestamp=0.
- FSM states:
  - IDLE: if enable, increment poll counter; when it reaches POLL_DIV-1, reset it and go to RD_REQ. If !enable, hold counter at 0.
  - RD_REQ: drive address=3, chipselect=1, write_n=1. Next state is RD_CAP.
  - RD_CAP: keep address=3, chipselect=0. Sample avm_readdata[DATA_W-1:0] into mask. If mask==0, go to IDLE; else go to CLR.
  - CLR: drive address=3, chipselect=1, write_n=0, writedata=mask. Push the event this cycle. Next state is IDLE.
- Outside RD_REQ, RD_CAP and CLR: address=0, chipselect=0, write_n=1.
- Only the bits that were read are cleared. Edges on other bits captured during the window survive to the next poll.
- A new edge on an already-set bit during CLR is lost, because the slave gives clear priority over detect. This is accepted behaviour.
- Dropping enable mid-transaction does not abort it. The FSM completes through CLR and then holds in IDLE.
- Push: if the FIFO is full at CLR, the event is dropped and overflow is set. Fullness is evaluated before any same-cycle pop.
- Pop: occurs when evt_valid && evt_ready. The FIFO is show-ahead: evt_data is valid whenever evt_valid=1.
- overflow: set has priority over ovf_clr in the same cycle.

## Timing
- One poll takes POLL_DIV (IDLE) + 3 cycles with a non-zero mask, and POLL_DIV + 2 cycles with a zero mask.
- evt_valid rises the cycle after CLR when the FIFO was empty. Latency from RD_REQ to evt_valid is 3 cycles.
- fifo_level updates on the clock edge following the push or pop. A simultaneous push and pop leaves the level unchanged.
- With POLL_DIV=1 and continuous edges, one event is produced every 4 cycles.

## Configuration
- PIO_POLL_TIMESTAMP_EN defined:
  - A free-running TS_W counter is instantiated. It increments every cycle from reset and wraps to 0.
  - The counter is sampled in RD_CAP.
  - evt_data = {timestamp, mask}.
- PIO_POLL_TIMESTAMP_EN undefined:
  - No counter is instantiated.
  - evt_data = mask, and EVT_W = DATA_W.

## Structure
- Package pio_poll_pkg contains:
  - state enum {IDLE, RD_REQ, RD_CAP, CLR}
  - PIO_ADDR_DATA=2'd0 and PIO_ADDR_EDGE=2'd3
- Sub-module pio_evt_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, and ports push, pop, full, empty and level.
- The top level holds the FSM, poll counter, timestamp, overflow flag and Avalon drive.

## Test plan
- Reset, enable=0 for 50 cycles: chipselect stays 0, evt_valid=0, and all outputs hold their reset values.
- enable=1, POLL_DIV=4, slave edge_capture=0x00: a read to address 3 occurs every 6 cycles, with no write and no event.
- Slave edge_capture=0x05:
  - The write to address 3 has writedata=0x05 in CLR.
  - evt_data[7:0]=0x05 and evt_valid=1 the next cycle.
  - The slave register then reads 0x00.
- Edge on bit 1 arriving between RD_CAP and CLR of a 0x04 capture: CLR writes 0x04 only, and the next poll yields an event with mask 0x02.
- evt_ready=0 with continuous 0x01 edges:
  - fifo_level saturates at 16 and overflow=1.
  - Pulsing ovf_clr clears overflow.
  - Setting evt_ready=1 drains 16 events in order.
- With PIO_POLL_TIMESTAMP_EN: two consecutive events differ in evt_data[TS_W+7:8] by exactly the poll period (POLL_DIV+3), including across the 0xFFFF→0x0000 wrap.
